fft_adc_loader: RTL

Input-side loader placed directly upstream of fft_top. It accepts a stream of ADC samples over a valid/ready handshake and writes one N-point frame into the FFT's four radix-4 RAM banks through the fft_top write ports (data, four write addresses, four write enables). Once the frame is complete it pulses the FFT start input, then holds off new samples until the FFT reports ready.

---
 rtl/fft_adc_loader_pkg.sv | 29 ++
 rtl/fft_adc_loader_if.sv | 34 +++
 rtl/fft_wr_addr_gen.sv | 45 ++++
 rtl/fft_adc_loader.sv | 100 ++++++++++
 4 files changed

// File: rtl/fft_adc_loader_pkg.sv
// Shared constants, FSM state type and sample-index helpers for the FFT input loader.
package fft_loader_pkg;

    localparam int N      = 4096;
    localparam int LOG2N  = $clog2(N);
    localparam int A_BIT  = LOG2N - 2;
    localparam int D_BIT  = 16;
    localparam int S_BIT  = D_BIT - 1;
    localparam int N_BANK = N / 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        KICK = 2'd1,
        ARM  = 2'd2,
        WAIT = 2'd3
    } state_t;

    typedef logic [LOG2N-1:0] k_t;

    // Banks are filled one after another, so the bank is simply the top two index bits.
    function automatic logic [1:0] k_to_bank(input k_t k);
        return k[LOG2N-1:A_BIT];
    endfunction

    function automatic logic [A_BIT-1:0] k_to_addr(input k_t k);
        return k[A_BIT-1:0];
    endfunction

endpackage

// File: rtl/fft_adc_loader_if.sv
// ADC sample stream plus fft_top write/start/ready signals seen by the loader.
interface fft_adc_loader_if;
    import fft_loader_pkg::*;

    logic [S_BIT-1:0] iADC_DATA;
    logic             iADC_VALID;
    logic             oADC_READY;
    logic [S_BIT-1:0] oDATA;
    logic [A_BIT-1:0] oADDR_WR_0;
    logic [A_BIT-1:0] oADDR_WR_1;
    logic [A_BIT-1:0] oADDR_WR_2;
    logic [A_BIT-1:0] oADDR_WR_3;
    logic             oWE_0;
    logic             oWE_1;
    logic             oWE_2;
    logic             oWE_3;
    logic             oSTART;
    logic             iFFT_RDY;
    logic             oBUSY;
    logic             oOVERRUN;

    modport slave (
        input  iADC_DATA, iADC_VALID, iFFT_RDY,
        output oADC_READY, oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oOVERRUN
    );

    modport master (
        output iADC_DATA, iADC_VALID, iFFT_RDY,
        input  oADC_READY, oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oOVERRUN
    );

endinterface

// File: rtl/fft_wr_addr_gen.sv
// Sample index counter and registered per-bank write enable / address outputs.
module fft_wr_addr_gen
    import fft_loader_pkg::*;
(
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  accept,
    output logic                  last,
    output logic [3:0]            we,
    output logic [3:0][A_BIT-1:0] addr
);

    k_t                    k_q, k_d;
    logic [3:0]            we_q, we_d;
    logic [3:0][A_BIT-1:0] addr_q, addr_d;

    always_comb begin
        k_d    = k_q;
        we_d   = '0;
        addr_d = addr_q;
        if (accept) begin
            // The counter is exactly log2(N) bits wide, so it wraps to 0 after N-1.
            k_d                    = k_q + k_t'(1);
            we_d[k_to_bank(k_q)]   = 1'b1;
            addr_d[k_to_bank(k_q)] = k_to_addr(k_q);
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            k_q    <= '0;
            we_q   <= '0;
            addr_q <= '0;
        end else begin
            k_q    <= k_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    assign last = (k_q == k_t'(N - 1));
    assign we   = we_q;
    assign addr = addr_q;

endmodule

// File: rtl/fft_adc_loader.sv
// Loads one N-point ADC frame into the fft_top RAM banks, kicks the FFT, waits for it to finish.
// Build option FFT_ADC_OFFSET_BIN_EN: treat ADC samples as offset-binary (MSB inverted on load).
//
// state | meaning
// LOAD  | accepting samples, writing banks 0..3 in order
// KICK  | last sample being written; oSTART fires next cycle
// ARM   | busy, waiting for FFT ready to drop (ignores a stale-high ready)
// WAIT  | busy, waiting for a rising edge on FFT ready
module fft_adc_loader
    import fft_loader_pkg::*;
(
    input logic               iCLK,
    input logic               iRESET,
    fft_adc_loader_if.slave   bus
);

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             ovr_q, ovr_d;
    logic             rdy_prev_q, rdy_prev_d;
    logic [S_BIT-1:0] data_q, data_d;
    logic [S_BIT-1:0] sample;
    logic             accept;
    logic             last;
    logic [3:0]       we;
    logic [3:0][A_BIT-1:0] addr;

`ifdef FFT_ADC_OFFSET_BIN_EN
    assign sample = {~bus.iADC_DATA[S_BIT-1], bus.iADC_DATA[S_BIT-2:0]};
`else
    assign sample = bus.iADC_DATA;
`endif

    assign accept = bus.iADC_VALID & ready_q;

    fft_wr_addr_gen u_wr_addr_gen (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .accept (accept),
        .last   (last),
        .we     (we),
        .addr   (addr)
    );

    always_comb begin
        state_d    = state_q;
        rdy_prev_d = bus.iFFT_RDY;
        case (state_q)
            LOAD:    if (accept && last) state_d = KICK;
            KICK:    state_d = ARM;
            ARM:     if (!bus.iFFT_RDY) state_d = WAIT;
            WAIT:    if (bus.iFFT_RDY && !rdy_prev_q) state_d = LOAD;
            default: state_d = LOAD;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        ready_d = (state_d == LOAD);
        busy_d  = (state_d == ARM) || (state_d == WAIT);
        start_d = (state_q == KICK);
        ovr_d   = ovr_q | (bus.iADC_VALID & ~ready_q);
        data_d  = accept ? sample : data_q;
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= LOAD;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            ovr_q      <= 1'b0;
            rdy_prev_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            ovr_q      <= ovr_d;
            rdy_prev_q <= rdy_prev_d;
            data_q     <= data_d;
        end
    end

    assign bus.oADC_READY = ready_q;
    assign bus.oBUSY      = busy_q;
    assign bus.oSTART     = start_q;
    assign bus.oOVERRUN   = ovr_q;
    assign bus.oDATA      = data_q;
    assign bus.oWE_0      = we[0];
    assign bus.oWE_1      = we[1];
    assign bus.oWE_2      = we[2];
    assign bus.oWE_3      = we[3];
    assign bus.oADDR_WR_0 = addr[0];
    assign bus.oADDR_WR_1 = addr[1];
    assign bus.oADDR_WR_2 = addr[2];
    assign bus.oADDR_WR_3 = addr[3];

endmodule
